// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes used by ALU control, the ALU and
// the multi-cycle mul/div sequencer, plus the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_NOP = 4'd3;
  localparam logic [3:0] ALU_DIV = 4'd4;
  localparam logic [3:0] ALU_MUL = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_SLL = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_XOR = 4'd10;
  localparam logic [3:0] ALU_NOR = 4'd11;
  localparam logic [3:0] ALU_SRA = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift registers and shared adder/subtractor for iterative unsigned
// shift-add multiply and restoring divide, plus the HI/LO result registers.
module muldiv_datapath import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             op_is_div_i,
  input  logic             commit_i,
  input  logic             dbz_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o
);

  // opnd_q holds the multiplicand or divisor; hi_q/lo_q form the
  // accumulator+multiplier pair for mul and the remainder+quotient for div.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   add_x, add_y;
  logic             add_cin;
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH:0]   mul_acc;
  logic             div_ge;
  logic [WIDTH-1:0] hi_step, lo_step;

  // Division subtracts via x + ~y + 1; the carry out means "no borrow".
  always_comb begin
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    if (op_is_div_i) begin
      add_x   = rem_shift;
      add_y   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, hi_q};
      add_y   = {1'b0, opnd_q};
      add_cin = 1'b0;
    end
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};

    div_ge  = add_sum[WIDTH+1];
    mul_acc = lo_q[0] ? add_sum[WIDTH:0] : {1'b0, hi_q};

    if (op_is_div_i) begin
      hi_step = div_ge ? add_sum[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      hi_step = mul_acc[WIDTH:1];
      lo_step = {mul_acc[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    if (load_i) begin
      opnd_d = op_is_div_i ? op_b_i : op_a_i;
      hi_d   = '0;
      lo_d   = op_is_div_i ? op_a_i : op_b_i;
    end else if (step_i) begin
      hi_d = hi_step;
      lo_d = lo_step;
    end
    if (commit_i) begin
      if (dbz_i) begin
        res_hi_d = op_a_i;
        res_lo_d = '1;
      end else begin
        res_hi_d = hi_step;
        res_lo_d = lo_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign result_hi_o = res_hi_q;
  assign result_lo_o = res_lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV controller beside the EX-stage ALU: accepts a request,
// stalls the pipeline for WIDTH iterations and presents a HI/LO result.
module muldiv_sequencer import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic             div_by_zero_o
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic is_mul_code, is_div_code, accept, last_iter, b_is_zero;
  logic dp_load, dp_step, dp_commit, dp_dbz, dp_op_is_div;

  assign is_mul_code = (alu_ctrl_i == ALU_MUL);
  assign is_div_code = (alu_ctrl_i == ALU_DIV);
  assign b_is_zero   = (op_b_i == '0);
  assign accept      = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i &&
                       (is_mul_code || is_div_code) && !flush_i;
  assign last_iter   = (cnt_q == CNT_W'(WIDTH-1));

  // A divide by zero skips iteration entirely and completes on the accept edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dbz_d     = dbz_q;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    dp_commit = 1'b0;
    dp_dbz    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          if (is_div_code && b_is_zero) begin
            state_d   = ST_DONE;
            dbz_d     = 1'b1;
            dp_commit = 1'b1;
            dp_dbz    = 1'b1;
          end else begin
            state_d = is_div_code ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          dp_step = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_iter) begin
            dp_commit = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d       = (state_d == ST_MUL) || (state_d == ST_DIV);
    done_d       = (state_d == ST_DONE);
    dp_op_is_div = accept ? is_div_code : (state_q == ST_DIV);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (dp_load),
    .step_i      (dp_step),
    .op_is_div_i (dp_op_is_div),
    .commit_i    (dp_commit),
    .dbz_i       (dp_dbz),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .result_hi_o (result_hi_o),
    .result_lo_o (result_lo_o)
  );

  assign stall_o       = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and datapath for the MUL (ALU code 5) and DIV (ALU code 4) operations issued by the ALU control unit.
- Sits beside the single-cycle ALU in EX.
- Accepts a start request with operands, runs an iterative unsigned shift-add multiply or restoring divide, and stalls the pipeline until done.
- Presents a HI/LO result pair, MIPS style.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_i  in  1  request from EX stage, sampled each rising edge.
alu_ctrl_i  in  4  ALU control code; 5 = mul, 4 = div; all other codes are ignored.
op_a_i  in  WIDTH  multiplicand or dividend (unsigned).
op_b_i  in  WIDTH  multiplier or divisor (unsigned).
flush_i  in  1  pipeline flush; aborts any operation in flight.
stall_o  out  1  combinational pipeline stall.
busy_o  out  1  registered; high in MUL or DIV state.
done_o  out  1  one-cycle pulse; result is valid.
result_hi_o  out  WIDTH  mul: upper product half; div: remainder.
result_lo_o  out  WIDTH  mul: lower product half; div: quotient.
div_by_zero_o  out  1  high with done_o when the divisor was 0; held until the next accept.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, counter=0; busy_o, done_o, div_by_zero_o, result_hi_o, result_lo_o all 0.
- Reset asserted mid-operation aborts immediately. No done_o is produced.
- States:
  - IDLE
  - MUL
  - DIV
  - DONE
- Accept condition: state in {IDLE, DONE} AND start_i AND alu_ctrl_i in {4,5} AND !flush_i.
  - Start with any other code: no state change, no stall.
- On the accept edge:
  - Latch operands, clear the accumulator/remainder, set counter=0, clear div_by_zero_o.
  - Next state is MUL or DIV.
  - Exception: div with op_b_i==0 goes directly to DONE.
- MUL iteration, one per edge:
  - If multiplier LSB is 1, add the multiplicand into the upper half of the 2*WIDTH accumulator.
  - Shift the {carry, acc} pair right by 1.
  - counter+1.
- DIV iteration, one per edge:
  - Shift {rem, quot} left by 1.
  - Trial-subtract the divisor from rem. If non-negative, commit the subtraction and set quot LSB=1.
  - counter+1.
- Completion: the edge performing iteration WIDTH (counter==WIDTH-1) writes the result registers and moves to DONE.
- Latency: done_o is high in the cycle following the WIDTH-th edge after the accept edge, i.e. 32 edges for WIDTH=32.
- Divide by zero:
  - done_o is high in the cycle after the accept edge.
  - lo = all ones, hi = op_a_i, div_by_zero_o=1.
- DONE:
  - done_o=1 for exactly one cycle, then IDLE.
  - A new accept in DONE is legal and goes straight to MUL/DIV.
- stall_o = (accept condition true) OR state in {MUL, DIV}.
  - Stall is low during the DONE cycle, so EX consumes the result there.
- Result registers change only at completion. Between completions they hold their last value.
- flush_i in MUL/DIV: next state IDLE, no done_o, result registers unchanged.
- flush_i together with start_i: flush wins, and the request is not accepted.
- Overflow: not possible. The product uses 2*WIDTH bits and the quotient fits in WIDTH.

Decomposition:
- Shared package (alu_pkg):
  - ALU control code constants: AND=0, OR=1, ADD=2, NOP=3, DIV=4, MUL=5, SUB=6, SLT=7, SLL=8, SRL=9, XOR=10, NOR=11, SRA=12.
  - The same constants are used by the ALU control unit and the ALU.
  - The sequencer state enum (2-bit) also lives here.
- One sub-module, muldiv_datapath:
  - Owns the operand, accumulator and remainder shift registers and the shared WIDTH+1-bit adder/subtractor.
  - Controlled by load, step, op_is_div and commit strobes from the FSM in muldiv_sequencer.

Test Plan:
- mul 7 x 6: stall_o high from the accept cycle. done_o at edge 32 with hi=0, lo=42, busy_o low afterwards.
- mul 0xFFFFFFFF x 0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- div 100 / 7: lo=14, hi=2, div_by_zero_o=0, latency 32 edges.
- div 5 / 0: done_o one edge after accept, lo=0xFFFFFFFF, hi=5, div_by_zero_o=1. Then a new start in the DONE cycle is accepted.
- mul started, flush_i at edge 10: IDLE next edge, no done_o, results keep prior values. start_i with alu_ctrl_i=2 gives no stall and no state change.
- rst_n dropped asynchronously mid-div: outputs zero immediately, no done_o. After release, div 9/3 completes with lo=3, hi=0.
